// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the pipeline writeback (P)
// and the multicycle unit (M); P has priority, M is promoted after MAX_WAIT refusals.
module regfile_wb_arbiter #(
  parameter int RW       = 5,
  parameter int W        = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_valid,
  input  logic [RW-1:0] p_addr,
  input  logic [W-1:0]  p_data,
  output logic          p_ready,
  input  logic          m_valid,
  input  logic [RW-1:0] m_addr,
  input  logic [W-1:0]  m_data,
  output logic          m_ready,
  output logic          rf_write_en,
  output logic [RW-1:0] rf_rd_addr,
  output logic [W-1:0]  rf_rd_data,
  output logic          stall_req,
  input  logic [RW-1:0] q_addr,
  output logic          q_hit
);
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic {P_PRI = 1'b0, M_PRI = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          p_nz, m_nz, collide, p_win, m_win, m_refused;

  always_comb begin
    p_nz    = p_valid && (p_addr != '0);
    m_nz    = m_valid && (m_addr != '0);
    collide = p_nz && m_nz && (p_addr == m_addr);
    // On a same-register collision the younger pipeline write wins and M is dropped.
    p_win   = p_nz && (!m_nz || collide || state == P_PRI);
    m_win   = m_nz && !collide && (!p_nz || state == M_PRI);
    // r0 writes are acknowledged immediately and never touch the port.
    p_ready   = rst && p_valid && ((p_addr == '0) || p_win);
    m_ready   = rst && m_valid && ((m_addr == '0) || m_win || collide);
    stall_req = rst && p_valid && !p_ready;
    m_refused = rst && m_valid && !m_ready;
    q_hit = rst && (q_addr != '0) &&
            ((rf_write_en && rf_rd_addr == q_addr) ||
             (p_valid && p_addr == q_addr) ||
             (m_valid && m_addr == q_addr));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= P_PRI;
      wait_cnt    <= '0;
      rf_write_en <= 1'b0;
      rf_rd_addr  <= '0;
      rf_rd_data  <= '0;
    end else begin
      if (p_win) begin
        rf_write_en <= 1'b1;
        rf_rd_addr  <= p_addr;
        rf_rd_data  <= p_data;
      end else if (m_win) begin
        rf_write_en <= 1'b1;
        rf_rd_addr  <= m_addr;
        rf_rd_data  <= m_data;
      end else begin
        rf_write_en <= 1'b0;
      end

      case (state)
        P_PRI: begin
          if (m_valid && m_ready) begin
            wait_cnt <= '0;
          end else if (m_refused) begin
            if (wait_cnt == CW'(MAX_WAIT - 1)) state <= M_PRI;
            else wait_cnt <= wait_cnt + 1'b1;
          end
        end
        M_PRI: begin
          // Leave once M has been served or has withdrawn its request.
          if (!m_valid || m_ready) begin
            state    <= P_PRI;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= P_PRI;
          wait_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, P-only, contention/aging, collision,
// r0 requests, hazard query and reset mid-operation.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid, m_valid;
  logic [4:0]  p_addr, m_addr, q_addr;
  logic [31:0] p_data, m_data;
  logic        p_ready, m_ready, rf_write_en, stall_req, q_hit;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.RW(5), .W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .rf_write_en(rf_write_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .stall_req(stall_req), .q_addr(q_addr), .q_hit(q_hit)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic v, input logic [4:0] a, input logic [31:0] d);
    p_valid = v; p_addr = a; p_data = d;
  endtask

  task automatic set_m(input logic v, input logic [4:0] a, input logic [31:0] d);
    m_valid = v; m_addr = a; m_data = d;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"},   rf_write_en, we);
    check({tag, "_addr"}, rf_rd_addr,  a);
    check({tag, "_data"}, rf_rd_data,  d);
  endtask

  initial begin
    rst = 1'b0; q_addr = 5'd5;
    set_p(1'b1, 5'd5, 32'hDEADBEEF);
    set_m(1'b1, 5'd7, 32'h77);
    #2;
    // Reset: combinational outputs forced low, registers cleared.
    check("rst_p_ready", p_ready, 1'b0);
    check("rst_m_ready", m_ready, 1'b0);
    check("rst_stall",   stall_req, 1'b0);
    check("rst_q_hit",   q_hit, 1'b0);
    tick();
    check_rf("rst_rf", 1'b0, 5'd0, 32'd0);

    // P only.
    rst = 1'b1;
    set_m(1'b0, 5'd0, 32'd0);
    #1;
    check("ponly_p_ready", p_ready, 1'b1);
    check("ponly_stall",   stall_req, 1'b0);
    tick();
    check_rf("ponly_rf", 1'b1, 5'd5, 32'hDEADBEEF);
    set_p(1'b0, 5'd0, 32'd0);
    tick();
    check_rf("ponly_idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // Contention: P wins 4 cycles, then M is promoted.
    set_p(1'b1, 5'd3, 32'h33);
    set_m(1'b1, 5'd7, 32'h77);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d_p_ready", i), p_ready, 1'b1);
      check($sformatf("cont%0d_m_ready", i), m_ready, 1'b0);
      tick();
      check_rf($sformatf("cont%0d_rf", i), 1'b1, 5'd3, 32'h33);
    end
    #1;
    check("cont4_p_ready", p_ready, 1'b0);
    check("cont4_m_ready", m_ready, 1'b1);
    check("cont4_stall",   stall_req, 1'b1);
    tick();
    check_rf("cont4_rf", 1'b1, 5'd7, 32'h77);
    set_m(1'b0, 5'd0, 32'd0);
    #1;
    check("cont5_p_ready", p_ready, 1'b1);
    check("cont5_stall",   stall_req, 1'b0);
    tick();
    check_rf("cont5_rf", 1'b1, 5'd3, 32'h33);

    // Collision on r9: P written, M accepted and dropped.
    set_p(1'b1, 5'd9, 32'd1);
    set_m(1'b1, 5'd9, 32'd2);
    #1;
    check("coll_p_ready", p_ready, 1'b1);
    check("coll_m_ready", m_ready, 1'b1);
    tick();
    check_rf("coll_rf", 1'b1, 5'd9, 32'd1);
    set_p(1'b0, 5'd0, 32'd0);
    set_m(1'b0, 5'd0, 32'd0);
    tick();
    check_rf("coll_idle", 1'b0, 5'd9, 32'd1);

    // r0 from P alongside M to r4.
    set_p(1'b1, 5'd0, 32'hAA);
    set_m(1'b1, 5'd4, 32'h44);
    #1;
    check("r0_p_ready", p_ready, 1'b1);
    check("r0_m_ready", m_ready, 1'b1);
    tick();
    check_rf("r0_rf", 1'b1, 5'd4, 32'h44);

    // Hazard on r12.
    set_p(1'b1, 5'd2, 32'h22);
    set_m(1'b1, 5'd12, 32'hC0FFEE);
    q_addr = 5'd12;
    #1;
    check("haz_m_ready", m_ready, 1'b0);
    check("haz_q_hit_pend", q_hit, 1'b1);
    tick();
    set_p(1'b0, 5'd0, 32'd0);
    #1;
    check("haz_m_accept", m_ready, 1'b1);
    check("haz_q_hit_acc", q_hit, 1'b1);
    tick();
    set_m(1'b0, 5'd0, 32'd0);
    #1;
    check_rf("haz_rf", 1'b1, 5'd12, 32'hC0FFEE);
    check("haz_q_hit_wr", q_hit, 1'b1);
    tick();
    check("haz_q_hit_done", q_hit, 1'b0);
    q_addr = 5'd0;
    set_p(1'b1, 5'd0, 32'd0);
    #1;
    check("haz_q_r0", q_hit, 1'b0);
    tick();
    set_p(1'b0, 5'd0, 32'd0);

    // Drive into M_PRI with a write in flight, then reset.
    set_p(1'b1, 5'd3, 32'h33);
    set_m(1'b1, 5'd7, 32'h77);
    repeat (4) tick();
    check("pre_rst_we", rf_write_en, 1'b1);
    check("pre_rst_mpri", m_ready, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_m_ready", m_ready, 1'b0);
    check("mid_rst_stall",   stall_req, 1'b0);
    tick();
    check_rf("mid_rst_rf", 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_p_ready", p_ready, 1'b1);
    check("post_rst_m_ready", m_ready, 1'b0);
    tick();
    check_rf("post_rst_rf", 1'b1, 5'd3, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
